if_fetch: RTL and testbench

Instruction-fetch initiator that drives the instruction ROM's chip-enable and address ports and captures the returned instruction words. It keeps the program counter (PC) and buffers fetched (pc, inst) pairs in a small FIFO. That FIFO feeds the IF/ID boundary through a valid/ready handshake. It also accepts branch/jump redirects from later stages and flushes wrong-path fetches.

---
 rtl/if_fetch.sv | 112 +++++++++++
 tb/tb_if_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and
// buffers (pc, inst) pairs in a small FIFO that feeds decode over valid/ready.
module if_fetch #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              id_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {BOOT, FETCH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [INST_W-1:0] inst_mem [FIFO_DEPTH];

  logic              valid;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target_aligned;

  assign valid          = (count_q != '0);
  assign target_aligned = branch_target_i & ~ADDR_W'(3);

  // Fetch enable is decoded from registered state only, so neither the
  // redirect nor the decode handshake reaches the ROM combinationally.
  assign rom_ce_o   = (state_q == FETCH) && (count_q < CW'(FIFO_DEPTH));
  assign rom_addr_o = rom_ce_o ? pc_q : '0;

  assign push = rom_ce_o && !branch_flag_i;
  assign pop  = valid && id_ready_i;

  assign if_valid_o = valid;
  assign if_pc_o    = valid ? pc_mem[rd_ptr_q]   : '0;
  assign if_inst_o  = valid ? inst_mem[rd_ptr_q] : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (state_q == BOOT) begin
      state_d = FETCH;
    end

    // A redirect flushes everything, including this cycle's fetch and pop.
    if (branch_flag_i) begin
      pc_d     = target_aligned;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= rom_inst_i;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed boot/backpressure/redirect/wrap/reset scenarios
// plus a long randomized run checked against a queue-based reference model.
module tb_if_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch #(.ADDR_W(32), .INST_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .id_ready_i      (id_ready_i)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle k0+1 (first cycle after the reset edge).
  task automatic reset_dut();
    rst = 1'b1; branch_flag_i = 1'b0; branch_target_i = 32'h0; id_ready_i = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b exp=0", rom_ce_o); end
    total++; if (rom_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", rom_addr_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid_o); end
    total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", if_pc_o); end
    total++; if (if_inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", if_inst_o); end
  endtask

  task automatic test_boot();
    reset_dut();
    total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL boot_ce_k1 got=%b exp=0", rom_ce_o); end
    tick();
    total++; if (rom_ce_o !== 1'b1) begin bad++; $display("FAIL boot_ce_k2 got=%b exp=1", rom_ce_o); end
    total++; if (rom_addr_o !== 32'h0) begin bad++; $display("FAIL boot_addr_k2 got=%h exp=0", rom_addr_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL boot_valid_k2 got=%b exp=0", if_valid_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL boot_valid[%0d] got=%b exp=1", i, if_valid_o); end
      total++; if (if_pc_o !== 32'(i * 4)) begin bad++; $display("FAIL boot_pc[%0d] got=%h exp=%h", i, if_pc_o, 32'(i * 4)); end
      total++; if (if_inst_o !== 32'(8'h11 * (i + 1))) begin bad++; $display("FAIL boot_inst[%0d] got=%h exp=%h", i, if_inst_o, 32'(8'h11 * (i + 1))); end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    tick();
    tick();
    id_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin bad++; $display("FAIL bp_hold[%0d] got valid=%b pc=%h exp valid=1 pc=0", i, if_valid_o, if_pc_o); end
      if (i >= 1) begin
        total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL bp_ce_full[%0d] got=%b exp=0", i, rom_ce_o); end
      end
      tick();
    end
    id_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'(j * 4)) begin bad++; $display("FAIL bp_release[%0d] got valid=%b pc=%h exp pc=%h", j, if_valid_o, if_pc_o, 32'(j * 4)); end
      total++; if (if_inst_o !== rom_word(32'(j * 4))) begin bad++; $display("FAIL bp_inst[%0d] got=%h exp=%h", j, if_inst_o, rom_word(32'(j * 4))); end
      tick();
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    id_ready_i = 1'b0;
    tick(); tick(); tick();
    total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL redir_full_ce got=%b exp=0", rom_ce_o); end
    branch_flag_i = 1'b1; branch_target_i = 32'h107;
    tick();
    branch_flag_i = 1'b0; id_ready_i = 1'b1;
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL redir_valid_n1 got=%b exp=0", if_valid_o); end
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h104) begin bad++; $display("FAIL redir_addr_n1 got ce=%b addr=%h exp ce=1 addr=104", rom_ce_o, rom_addr_o); end
    for (int j = 0; j < 2; j++) begin
      tick();
      total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h104 + 32'(4 * j)) begin bad++; $display("FAIL redir_pc[%0d] got valid=%b pc=%h exp pc=%h", j, if_valid_o, if_pc_o, 32'h104 + 32'(4 * j)); end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    tick(); tick();
    branch_flag_i = 1'b1; branch_target_i = 32'h2000;
    tick();
    branch_flag_i = 1'b0;
    total++; if (if_valid_o !== 1'b0 || rom_addr_o !== 32'h2000) begin bad++; $display("FAIL b2b_n1 got valid=%b addr=%h exp valid=0 addr=2000", if_valid_o, rom_addr_o); end
    for (int j = 0; j < 2; j++) begin
      tick();
      total++; if (if_pc_o !== 32'h2000 + 32'(4 * j) || if_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_pc[%0d] got valid=%b pc=%h exp pc=%h", j, if_valid_o, if_pc_o, 32'h2000 + 32'(4 * j)); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    reset_dut();
    tick(); tick();
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
    tick();
    branch_flag_i = 1'b0;
    total++; if (if_valid_o !== 1'b0 || rom_addr_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_n1 got valid=%b addr=%h", if_valid_o, rom_addr_o); end
    exp_pc = 32'hFFFF_FFF8;
    for (int j = 0; j < 3; j++) begin
      tick();
      total++; if (if_pc_o !== exp_pc || if_inst_o !== rom_word(exp_pc)) begin bad++; $display("FAIL wrap_pc[%0d] got pc=%h inst=%h exp pc=%h inst=%h", j, if_pc_o, if_inst_o, exp_pc, rom_word(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    id_ready_i = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h500;
    tick();
    rst = 1'b0; branch_flag_i = 1'b0; id_ready_i = 1'b1;
    total++; if ({rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o} !== '0) begin bad++; $display("FAIL rmid_zero got ce=%b addr=%h v=%b pc=%h inst=%h exp all 0", rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o); end
    tick();
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_k2 got ce=%b addr=%h v=%b", rom_ce_o, rom_addr_o, if_valid_o); end
    tick();
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== 32'h11) begin bad++; $display("FAIL rmid_k3 got v=%b pc=%h inst=%h exp v=1 pc=0 inst=11", if_valid_o, if_pc_o, if_inst_o); end
  endtask

  // Reference: an in-order queue of fetched PCs, a fetch PC and a boot flag.
  task automatic test_random();
    logic [31:0] m_q[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_boot = 1'b1;
    bit          e_ce;
    logic [31:0] e_pc;
    for (int n = 0; n < 3000; n++) begin
      rst             = (n == 0) || ($urandom_range(0, 99) == 0);
      branch_flag_i   = ($urandom_range(0, 9) == 0);
      branch_target_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      id_ready_i      = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      e_ce = !m_boot && (m_q.size() < DEPTH);
      if (rst) begin
        m_boot = 1'b1; m_pc = 32'h0; m_q.delete();
      end else begin
        m_boot = 1'b0;
        if (branch_flag_i) begin
          m_q.delete(); m_pc = {branch_target_i[31:2], 2'b00};
        end else begin
          if (m_q.size() != 0 && id_ready_i) void'(m_q.pop_front());
          if (e_ce) begin m_q.push_back(m_pc); m_pc = m_pc + 32'd4; end
        end
      end
      #1;
      e_ce = !m_boot && (m_q.size() < DEPTH);
      e_pc = (m_q.size() != 0) ? m_q[0] : 32'h0;
      total++; if (rom_ce_o !== e_ce) begin bad++; $display("FAIL rnd_ce n=%0d got=%b exp=%b", n, rom_ce_o, e_ce); end
      total++; if (rom_addr_o !== (e_ce ? m_pc : 32'h0)) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, rom_addr_o, e_ce ? m_pc : 32'h0); end
      total++; if (if_valid_o !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, if_valid_o, m_q.size() != 0); end
      total++; if (if_pc_o !== e_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, if_pc_o, e_pc); end
      total++; if (if_inst_o !== ((m_q.size() != 0) ? rom_word(e_pc) : 32'h0)) begin bad++; $display("FAIL rnd_inst n=%0d got=%h exp=%h", n, if_inst_o, (m_q.size() != 0) ? rom_word(e_pc) : 32'h0); end
    end
  endtask

  initial begin
    rst = 1'b1; branch_flag_i = 1'b0; branch_target_i = 32'h0; id_ready_i = 1'b0;
    #1;
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
